hash_msg_stream: RTL and testbench

- Downstream consumer of hash_data.
- Latches the 9841-bit encoded vector and a one-byte hash prefix, then streams the message to the SHA-512 core as big-endian 64-bit words with full SHA-512 padding.
- Output is 16-word (1024-bit) blocks with first/last-block markers.
- Sits between hash_data and the SHA-512 compression core in the Encap hash path.

---
 rtl/hash_msg_stream.sv | 168 ++++++++++++++++
 tb/tb_hash_msg_stream.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/hash_msg_stream.sv
// hash_msg_stream
//   Latches a MSG_BITS-wide encoded vector plus a one-byte prefix and streams
//   the byte string {prefix, msg bytes 0..MSG_BYTES-1} to a SHA-512 core as
//   big-endian 64-bit words. The stream carries full SHA-512 padding: a 0x80
//   byte, zero fill, then the 128-bit big-endian message bit length.
//
// Ports
//   clk, rst_n    : rising-edge clock, asynchronous active-low reset
//   start         : one-cycle pulse, accepted only while idle
//   prefix, msg   : sampled on an accepted start
//   busy          : high from the cycle after an accepted start until done
//   word_o        : current padded word, earliest byte in [63:56]
//   word_valid    : word_o valid; consumed when word_valid && word_ready
//   word_ready    : consumer accept
//   block_first   : word 0 of the first 1024-bit block
//   block_last    : word 15 of any block
//   msg_last      : final padded word
//   done          : one-cycle pulse after the final word is accepted
module hash_msg_stream #(
    parameter int MSG_BITS = 9841
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [7:0]          prefix,
    input  logic [MSG_BITS-1:0] msg,
    output logic                busy,
    output logic [63:0]         word_o,
    output logic                word_valid,
    input  logic                word_ready,
    output logic                block_first,
    output logic                block_last,
    output logic                msg_last,
    output logic                done
);

    localparam int MSG_BYTES   = (MSG_BITS + 7) / 8;
    localparam int PAD_W       = MSG_BYTES * 8;
    localparam int DATA_BYTES  = MSG_BYTES + 1;
    // Room for the 0x80 marker and the 16-byte length, rounded to 128-byte blocks.
    localparam int TOTAL_BYTES = ((DATA_BYTES + 1 + 16 + 127) / 128) * 128;
    localparam int TOTAL_WORDS = TOTAL_BYTES / 8;
    localparam int WCNT_W      = $clog2(TOTAL_WORDS);
    localparam logic [127:0] LEN_BITS = 128'(DATA_BYTES * 8);
    localparam logic [WCNT_W-1:0] LAST_W = WCNT_W'(TOTAL_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [WCNT_W-1:0]  wcnt;
    logic [PAD_W-1:0]   msg_q;
    logic [7:0]         prefix_q;

    // Source selection for the next word: the live inputs when loading word 0
    // at start, the latched copy afterwards.
    logic [PAD_W-1:0]   src_msg;
    logic [7:0]         src_pfx;
    int unsigned        nidx;
    logic [63:0]        nword;

    // Byte b of the padded stream.
    function automatic logic [7:0] stream_byte(input int unsigned b,
                                               input logic [7:0] pfx,
                                               input logic [PAD_W-1:0] m);
        logic [PAD_W-1:0] sh;
        logic [127:0]     lsh;
        if (b == 0) begin
            return pfx;
        end else if (b <= MSG_BYTES) begin
            sh = m >> (8 * (b - 1));
            return sh[7:0];
        end else if (b == DATA_BYTES) begin
            return 8'h80;
        end else if (b >= TOTAL_BYTES - 16) begin
            lsh = LEN_BITS >> (8 * (TOTAL_BYTES - 1 - b));
            return lsh[7:0];
        end
        return 8'h00;
    endfunction

    always_comb begin
        src_msg = (state == S_IDLE) ? PAD_W'(msg) : msg_q;
        src_pfx = (state == S_IDLE) ? prefix : prefix_q;
        nidx    = (state == S_IDLE) ? 0 : 32'(wcnt) + 1;
        nword   = '0;
        for (int i = 0; i < 8; i++) begin
            nword = {nword[55:0], stream_byte(8 * nidx + 32'(i), src_pfx, src_msg)};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_STREAM;
            S_STREAM: if (word_ready && wcnt == LAST_W) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Output word and flags are always loaded one index ahead, so word_ready
    // only gates a register enable and never reaches word_o combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_q       <= '0;
            prefix_q    <= '0;
            wcnt        <= '0;
            word_o      <= '0;
            word_valid  <= 1'b0;
            busy        <= 1'b0;
            block_first <= 1'b0;
            block_last  <= 1'b0;
            msg_last    <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        msg_q       <= PAD_W'(msg);
                        prefix_q    <= prefix;
                        wcnt        <= '0;
                        word_o      <= nword;
                        word_valid  <= 1'b1;
                        busy        <= 1'b1;
                        block_first <= 1'b1;
                        block_last  <= 1'b0;
                        msg_last    <= (TOTAL_WORDS == 1);
                    end
                end
                S_STREAM: begin
                    if (word_ready) begin
                        if (wcnt == LAST_W) begin
                            word_o      <= '0;
                            word_valid  <= 1'b0;
                            busy        <= 1'b0;
                            block_first <= 1'b0;
                            block_last  <= 1'b0;
                            msg_last    <= 1'b0;
                            done        <= 1'b1;
                        end else begin
                            wcnt        <= wcnt + 1'b1;
                            word_o      <= nword;
                            block_first <= 1'b0;
                            block_last  <= (nidx[3:0] == 4'hf);
                            msg_last    <= (nidx == TOTAL_WORDS - 1);
                        end
                    end
                end
                S_DONE: begin
                    done <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hash_msg_stream.sv
module tb_hash_msg_stream;

    localparam int MSG_BITS = 9841;
    localparam int NW       = 160;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [7:0]          prefix = '0;
    logic [MSG_BITS-1:0] msg = '0;
    logic                word_ready = 1'b0;
    logic                busy, word_valid, block_first, block_last, msg_last, done;
    logic [63:0]         word_o;

    hash_msg_stream #(.MSG_BITS(MSG_BITS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .prefix(prefix), .msg(msg),
        .busy(busy), .word_o(word_o), .word_valid(word_valid),
        .word_ready(word_ready), .block_first(block_first),
        .block_last(block_last), .msg_last(msg_last), .done(done)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    logic [63:0] ref_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Padded SHA-512 message built straight from the byte-level rules.
    function automatic void build_model(input logic [7:0] pfx, input logic [MSG_BITS-1:0] m);
        byte unsigned      q[$];
        logic [MSG_BITS+6:0] t;
        longint unsigned   len;
        logic [63:0]       w;
        exp_q.delete();
        q.push_back(pfx);
        t = {7'b0, m};
        for (int k = 0; k < (MSG_BITS + 7) / 8; k++) begin
            q.push_back(t[7:0]);
            t = t >> 8;
        end
        len = 64'(q.size()) * 8;
        q.push_back(8'h80);
        while (q.size() % 128 != 112) q.push_back(8'h00);
        for (int i = 15; i >= 0; i--)
            q.push_back(i >= 8 ? 8'h00 : 8'(len >> (8 * i)));
        for (int wi = 0; wi < q.size() / 8; wi++) begin
            w = '0;
            for (int b = 0; b < 8; b++) w = {w[55:0], 8'(q[8 * wi + b])};
            exp_q.push_back(w);
        end
    endfunction

    function automatic logic [MSG_BITS-1:0] rand_msg();
        logic [MSG_BITS-1:0] m;
        m = '0;
        for (int i = 0; i < (MSG_BITS + 31) / 32; i++) m = {m[MSG_BITS-33:0], 32'($urandom)};
        return m;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_word"}, word_o, 64'h0);
        check({tag, "_flags"}, 64'({busy, word_valid, block_first, block_last, msg_last, done}), 64'h0);
    endtask

    // Streams one message. stall: random backpressure; repulse: extra start
    // pulses with a different msg/prefix around word 40; rst_at: word index at
    // which rst_n is pulled low (-1 for none).
    task automatic run_stream(input string nm, input logic [7:0] pfx,
                              input logic [MSG_BITS-1:0] m, input bit stall,
                              input bit repulse, input int rst_at);
        int          n = 0;
        int          cyc = 0;
        int          dones = 0;
        bit          prev_stall = 1'b0;
        logic [63:0] prev_w = '0;
        logic [4:0]  prev_f = '0;
        logic [4:0]  cur_f;
        logic [4:0]  exp_f;
        build_model(pfx, m);
        got_q.delete();
        @(negedge clk);
        prefix = pfx;
        msg    = m;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({nm, "_latency"}, 64'({busy, word_valid}), 64'h3);
        while (n < NW && cyc < 4000) begin
            cur_f = {busy, word_valid, block_first, block_last, msg_last};
            if (rst_at == n) begin
                rst_n = 1'b0;
                #1;
                check_idle_outputs({nm, "_async_rst"});
                @(negedge clk);
                rst_n = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    if (done) dones++;
                end
                check({nm, "_no_done_after_rst"}, 64'(dones), 64'h0);
                check_idle_outputs({nm, "_idle_after_rst"});
                return;
            end
            if (prev_stall) begin
                check({nm, "_hold_word"}, word_o, prev_w);
                check({nm, "_hold_flags"}, 64'(cur_f), 64'(prev_f));
            end
            word_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (repulse && n >= 40 && n < 42) begin
                start  = 1'b1;
                prefix = ~pfx;
                msg    = ~m;
            end
            if (word_valid && word_ready) begin
                exp_f = {1'b1, 1'b1, n == 0, (n % 16) == 15, n == NW - 1};
                check($sformatf("%s_w%0d", nm, n), word_o, exp_q[n]);
                check($sformatf("%s_f%0d", nm, n), 64'(cur_f), 64'(exp_f));
                got_q.push_back(word_o);
                n++;
                prev_stall = 1'b0;
            end else begin
                prev_stall = word_valid;
            end
            prev_w = word_o;
            prev_f = cur_f;
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        word_ready = 1'b0;
        check({nm, "_accepts"}, 64'(n), 64'(NW));
        check({nm, "_done_pulse"}, 64'({done, busy, word_valid}), 64'h4);
        @(negedge clk);
        check({nm, "_done_cleared"}, 64'({done, busy, word_valid}), 64'h0);
    endtask

    logic [MSG_BITS-1:0] m;
    logic [7:0]          p;

    initial begin
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // All-zero message
        run_stream("zero", 8'h03, '0, 1'b0, 1'b0, -1);
        check("zero_count", 64'(got_q.size()), 64'(NW));
        if (got_q.size() == NW) begin
            check("zero_w0", got_q[0], 64'h0300000000000000);
            check("zero_w1", got_q[1], 64'h0);
            check("zero_w153", got_q[153], 64'h0);
            check("zero_w154", got_q[154], 64'h8000000000000000);
            check("zero_w159", got_q[159], 64'h0000000000002680);
        end

        // Ascending bytes at the start of msg
        m = '0;
        m[55:0] = 56'h77665544332211;
        run_stream("asc", 8'hAB, m, 1'b0, 1'b0, -1);
        if (got_q.size() > 0) check("asc_w0", got_q[0], 64'hAB11223344556677);

        // Only the top message bit set
        m = '0;
        m[MSG_BITS-1] = 1'b1;
        run_stream("topbit", 8'h00, m, 1'b0, 1'b0, -1);
        if (got_q.size() == NW) begin
            check("topbit_w153", got_q[153], 64'h0000000000000001);
            check("topbit_w154", got_q[154], 64'h8000000000000000);
        end

        // Random message, then the same message under random backpressure
        m = rand_msg();
        p = 8'($urandom);
        run_stream("rnd_free", p, m, 1'b0, 1'b0, -1);
        ref_q = got_q;
        run_stream("rnd_stall", p, m, 1'b1, 1'b0, -1);
        check("stall_len", 64'(got_q.size()), 64'(ref_q.size()));
        for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
            if (got_q[i] !== ref_q[i]) check($sformatf("stall_vs_free_%0d", i), got_q[i], ref_q[i]);

        // start re-pulsed mid-stream with different data
        m = rand_msg();
        run_stream("repulse", 8'($urandom), m, 1'b1, 1'b1, -1);

        // Reset mid-stream, then a fresh start
        run_stream("rst", 8'($urandom), rand_msg(), 1'b0, 1'b0, 80);
        run_stream("after_rst", 8'($urandom), rand_msg(), 1'b1, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
